leiwand_rv32_wait_mem: RTL and testbench
========================================

LEIWAND_RV32_WAIT_MEM -- requirements
Module: leiwand_rv32_wait_mem

Interface
REQ-001 Parameter WORDS, default 4096: number of 32-bit words in the array.
REQ-002 Parameter WAIT_STATES, default 0: extra cycles inserted before ready (legal range 0..15).
REQ-003 Parameter TOHOST_ADDR, default 32'h0000_1000: byte address of the halt/tohost register (word aligned, outside array range).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 valid  input  1  request present; held by the master until ready is seen.
REQ-007 ready  output  1  one-cycle response strobe.
REQ-008 wen  input  4  byte write enables, bit i covers wdata[8i+7:8i]; 4'b0000 means read.
REQ-009 addr  input  32  byte address; word index is addr[31:2], addr[1:0] ignored.
REQ-010 wdata  input  32  write data.
REQ-011 rdata  output  32  read data, valid while ready is high.
REQ-012 error  output  1  asserted with ready when the request hit neither array nor tohost.
REQ-013 halt  output  1  sticky flag, set by any write to TOHOST_ADDR.
REQ-014 halt_code  output  32  data of the last write to TOHOST_ADDR.

Function
REQ-015 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-016 IDLE: valid=1 sampled -> latch addr, wen, wdata; go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else go to RESP.
REQ-017 WAIT: counter decrements each cycle; at counter=0 go to RESP; valid/addr changes ignored (latched copy used).
REQ-018 Array access (read or byte-masked write) occurs on the edge entering RESP, using latched request.
REQ-019 RESP: ready=1 for exactly one cycle, rdata/error driven, then IDLE unconditionally.
REQ-020 Latency: valid sampled at edge n -> ready high in cycle n+1+WAIT_STATES; minimum 2 cycles per transaction.
REQ-021 valid still high in IDLE after RESP starts a new transaction (back-to-back permitted).
REQ-022 Write: only bytes with wen[i]=1 change; other bytes of the word preserved; rdata during a write response = 0.
REQ-023 Read: rdata = full 32-bit word at addr[31:2]; wen ignored in byte lanes.
REQ-024 Word index >= WORDS and addr != TOHOST_ADDR: no array change, rdata=0, error=1 with ready.
REQ-025 Write to TOHOST_ADDR (any wen nonzero): halt<=1, halt_code<=wdata (full word, wen mask ignored), array untouched, error=0.
REQ-026 Read of TOHOST_ADDR: rdata=halt_code, error=0.
REQ-027 ready, error low in all states except RESP; rdata=0 outside RESP.
REQ-028 Array contents are not initialised by the block; bench preloads via hierarchical access to array mem[0..WORDS-1].

Reset
REQ-029 rst=0 at any time: state=IDLE, counter=0, ready=0, error=0, rdata=0, halt=0, halt_code=0, immediately (asynchronous).
REQ-030 Reset in WAIT aborts the pending write (array unchanged); reset coincident with RESP entry edge: write discarded.
REQ-031 Array contents survive reset.
REQ-032 After rst returns high, first request sampled on the next rising edge.

Verification
REQ-033 WAIT_STATES=0, mem[5]=32'h11223344, read addr 32'h14 -> ready in cycle n+1, rdata=32'h11223344, error=0.
REQ-034 WAIT_STATES=3, write addr 32'h8 wdata 32'hAABBCCDD wen 4'b0101 onto mem[2]=32'h00000000 -> ready in cycle n+4, then mem[2]=32'h00BB00DD.
REQ-035 Valid held across two responses, addr 0 then 4 -> two ready pulses 2 cycles apart (WAIT_STATES=0), each with correct rdata.
REQ-036 Read addr (WORDS*4) -> ready with error=1, rdata=0; write there -> error=1, no array word changed.
REQ-037 Write 32'h1 to TOHOST_ADDR -> halt=1, halt_code=32'h1; subsequent read of TOHOST_ADDR returns 32'h1; rst low -> halt=0.
REQ-038 WAIT_STATES=5, write issued, rst pulsed low in 3rd WAIT cycle -> no ready, target word unchanged, ready=0 during and after reset.

Source files
------------

// File: rtl/leiwand_rv32_wait_mem_if.sv
// Request/response bus between an RV32 core and the wait-state memory.
// The master holds valid until ready is seen; ready is a one-cycle strobe.
interface leiwand_rv32_wait_mem_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;

    modport master (
        output valid,
        output wen,
        output addr,
        output wdata,
        input  ready,
        input  rdata,
        input  error
    );

    modport slave (
        input  valid,
        input  wen,
        input  addr,
        input  wdata,
        output ready,
        output rdata,
        output error
    );
endinterface

// File: rtl/leiwand_rv32_wait_mem.sv
// Word-addressed simulation memory with configurable wait states and a tohost halt register.
// One request in flight; the response is a single-cycle ready strobe.
module leiwand_rv32_wait_mem #(
    parameter int unsigned WORDS       = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic                          clk,
    input  logic                          rst,
    leiwand_rv32_wait_mem_if.slave        bus,
    output logic                          halt,
    output logic [31:0]                   halt_code
);

    localparam int unsigned AW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [29:0]  addr_q, addr_d;
    logic [3:0]   wen_q, wen_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         error_q, error_d;
    logic         halt_q, halt_d;
    logic [31:0]  halt_code_q, halt_code_d;

    logic [31:0]  mem [WORDS];

    logic [29:0]  req_addr;
    logic [3:0]   req_wen;
    logic [31:0]  req_wdata;
    logic [AW-1:0] req_idx;
    logic         req_in_array;
    logic         req_tohost;
    logic         go_resp;
    logic         mem_we;
    logic         resp;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];

    // With no wait states the access happens on the sampling edge, so decode the live bus.
    always_comb begin
        if (state_q == StIdle) begin
            req_addr  = bus.addr[31:2];
            req_wen   = bus.wen;
            req_wdata = bus.wdata;
        end else begin
            req_addr  = addr_q;
            req_wen   = wen_q;
            req_wdata = wdata_q;
        end
    end

    assign req_idx      = req_addr[AW-1:0];
    assign req_in_array = ({2'b00, req_addr} < WORDS);
    assign req_tohost   = (req_addr == TOHOST_ADDR[31:2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wen_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        rdata_d     = '0;
        error_d     = 1'b0;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        go_resp     = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    addr_d  = bus.addr[31:2];
                    wen_d   = bus.wen;
                    wdata_d = bus.wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end else begin
                        go_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (go_resp) begin
            state_d = StResp;
            cnt_d   = 4'd0;
            if (req_tohost) begin
                if (req_wen != 4'b0000) begin
                    halt_d      = 1'b1;
                    halt_code_d = req_wdata;
                end else begin
                    rdata_d = halt_code_q;
                end
            end else if (req_in_array) begin
                if (req_wen == 4'b0000) begin
                    rdata_d = mem[req_idx];
                end else begin
                    mem_we = 1'b1;
                end
            end else begin
                error_d = 1'b1;
            end
        end
    end

    // The array has no reset; a write landing on an edge while reset is asserted is dropped.
    always @(posedge clk) begin
        if (mem_we && rst) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wen[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp      = (state_q == StResp);
    assign bus.ready = resp;
    assign bus.error = resp & error_q;
    assign bus.rdata = resp ? rdata_q : 32'h0;
    assign halt      = halt_q;
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_leiwand_rv32_wait_mem.sv
// Directed bench: three instances (0, 3 and 5 wait states) sharing clock, reset and request lines.
module tb_leiwand_rv32_wait_mem;

    localparam int unsigned Words = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  vld = 3'b000;
    logic [3:0]  wen = 4'b0000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        h0, h3, h5;
    logic [31:0] hc0, hc3, hc5;

    int checks = 0;
    int errors = 0;

    leiwand_rv32_wait_mem_if b0();
    leiwand_rv32_wait_mem_if b3();
    leiwand_rv32_wait_mem_if b5();

    assign b0.valid = vld[0];
    assign b3.valid = vld[1];
    assign b5.valid = vld[2];
    assign b0.wen = wen;
    assign b3.wen = wen;
    assign b5.wen = wen;
    assign b0.addr = addr;
    assign b3.addr = addr;
    assign b5.addr = addr;
    assign b0.wdata = wdata;
    assign b3.wdata = wdata;
    assign b5.wdata = wdata;

    leiwand_rv32_wait_mem #(.WORDS(Words), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0), .halt(h0), .halt_code(hc0)
    );
    leiwand_rv32_wait_mem #(.WORDS(Words), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .bus(b3), .halt(h3), .halt_code(hc3)
    );
    leiwand_rv32_wait_mem #(.WORDS(Words), .WAIT_STATES(5)) u5 (
        .clk(clk), .rst(rst), .bus(b5), .halt(h5), .halt_code(hc5)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(int i);
        if (i == 5) return 32'h1122_3344;
        return {8'(i), 8'hC3, 8'(i + 1), 8'h3C};
    endfunction

    function automatic logic rdy(int s);
        case (s)
            0: return b0.ready;
            1: return b3.ready;
            default: return b5.ready;
        endcase
    endfunction

    function automatic logic [31:0] rdat(int s);
        case (s)
            0: return b0.rdata;
            1: return b3.rdata;
            default: return b5.rdata;
        endcase
    endfunction

    function automatic logic erro(int s);
        case (s)
            0: return b0.error;
            1: return b3.error;
            default: return b5.error;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lat counts negedges from request drive to the ready sample: 2 + wait states.
    task automatic txn(input int s, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int lat);
        @(posedge clk);
        #1;
        wen   = w;
        addr  = a;
        wdata = d;
        vld   = 3'b000;
        vld[s] = 1'b1;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rdy(s)) begin
                rd = rdat(s);
                er = erro(s);
                break;
            end
        end
        vld = 3'b000;
    endtask

    initial begin
        logic [31:0] rd, rd2;
        logic        er;
        int          lat, gap;
        logic        seen;

        for (int i = 0; i < int'(Words); i++) begin
            u0.mem[i] = pat(i);
            u3.mem[i] = 32'h0;
            u5.mem[i] = 32'h0;
        end
        u5.mem[3] = 32'h1234_5678;

        #1;
        chk("reset_ready", 32'(b0.ready), 32'h0);
        chk("reset_error", 32'(b0.error), 32'h0);
        chk("reset_rdata", b0.rdata, 32'h0);
        chk("reset_halt", 32'(h0), 32'h0);
        chk("reset_halt_code", hc0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Zero wait states: single word read.
        txn(0, 4'b0000, 32'h14, 32'h0, rd, er, lat);
        chk("ws0_read_latency", 32'(lat), 32'd2);
        chk("ws0_read_rdata", rd, 32'h1122_3344);
        chk("ws0_read_error", 32'(er), 32'h0);
        @(negedge clk);
        chk("ws0_ready_one_cycle", 32'(b0.ready), 32'h0);
        chk("ws0_rdata_idle", b0.rdata, 32'h0);

        // Three wait states: byte-masked write.
        txn(1, 4'b0101, 32'h8, 32'hAABB_CCDD, rd, er, lat);
        chk("ws3_write_latency", 32'(lat), 32'd5);
        chk("ws3_write_rdata", rd, 32'h0);
        chk("ws3_write_error", 32'(er), 32'h0);
        chk("ws3_write_mem", u3.mem[2], 32'h00BB_00DD);
        txn(1, 4'b0000, 32'hA, 32'h0, rd, er, lat);
        chk("ws3_readback", rd, 32'h00BB_00DD);

        // Back-to-back: valid held, address advanced after the first ready.
        @(posedge clk);
        #1;
        wen = 4'b0000;
        addr = 32'h0;
        vld[0] = 1'b1;
        lat = 0;
        while (lat < 20 && !b0.ready) begin
            @(negedge clk);
            lat++;
        end
        rd = b0.rdata;
        addr = 32'h4;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!b0.ready && gap < 20);
        rd2 = b0.rdata;
        vld = 3'b000;
        chk("b2b_first_latency", 32'(lat), 32'd2);
        chk("b2b_first_rdata", rd, pat(0));
        chk("b2b_gap", 32'(gap), 32'd2);
        chk("b2b_second_rdata", rd2, pat(1));

        // Out of range (word index == Words).
        txn(0, 4'b0000, Words * 4, 32'h0, rd, er, lat);
        chk("oor_read_error", 32'(er), 32'h1);
        chk("oor_read_rdata", rd, 32'h0);
        @(negedge clk);
        chk("oor_error_after_resp", 32'(b0.error), 32'h0);
        txn(0, 4'b1111, Words * 4, 32'hFFFF_FFFF, rd, er, lat);
        chk("oor_write_error", 32'(er), 32'h1);
        for (int i = 0; i < int'(Words); i++) begin
            chk($sformatf("oor_mem_%0d", i), u0.mem[i], pat(i));
        end

        // tohost halt register.
        txn(0, 4'b0001, 32'h1000, 32'h1, rd, er, lat);
        chk("tohost_write_error", 32'(er), 32'h0);
        chk("tohost_halt", 32'(h0), 32'h1);
        chk("tohost_code", hc0, 32'h1);
        txn(0, 4'b0000, 32'h1000, 32'h0, rd, er, lat);
        chk("tohost_read", rd, 32'h1);
        chk("tohost_read_error", 32'(er), 32'h0);
        txn(0, 4'b1000, 32'h1000, 32'hDEAD_BEEF, rd, er, lat);
        chk("tohost_full_word", hc0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_clears_halt", 32'(h0), 32'h0);
        chk("reset_clears_code", hc0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        txn(0, 4'b0000, 32'h14, 32'h0, rd, er, lat);
        chk("array_survives_reset", rd, 32'h1122_3344);

        // Five wait states: reset during the third wait cycle aborts the write.
        @(posedge clk);
        #1;
        wen = 4'b1111;
        addr = 32'hC;
        wdata = 32'h0;
        vld[2] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        vld = 3'b000;
        #1;
        seen = b5.ready;
        repeat (2) begin
            @(negedge clk);
            seen = seen | b5.ready;
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            seen = seen | b5.ready;
        end
        chk("abort_no_ready", 32'(seen), 32'h0);
        chk("abort_mem_unchanged", u5.mem[3], 32'h1234_5678);
        txn(2, 4'b0000, 32'hC, 32'h0, rd, er, lat);
        chk("ws5_read_latency", 32'(lat), 32'd7);
        chk("ws5_read_rdata", rd, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
